// File: rtl/fpmult_radix.sv
// Iterative fixed-point multiplier: c = (a*b) >> D, retiring K multiplier bits per cycle,
// with per-transaction rounding, optional saturation and an overflow flag.
//
// Handshake: operands transfer on a clock edge where recv_val && recv_rdy; the result
// transfers on an edge where send_val && send_rdy. recv_rdy and send_val are registered
// and never high together, so at most one transaction is in flight.
module fpmult_radix #(
  parameter int N    = 32,
  parameter int D    = 16,
  parameter int SIGN = 1,
  parameter int K    = 2,
  parameter int SAT  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rnd,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int W     = 2 * N;
  localparam int STEPS = N / K;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int RSH   = (D > 0) ? D - 1 : 0;

  localparam logic [CW-1:0] LAST    = CW'(STEPS - 1);
  localparam logic [W-1:0]  RND_ONE = (D > 0) ? (W'(1) << RSH) : '0;
  localparam logic [N-1:0]  SMAX    = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SMIN    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  UMAX    = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  a_sh;
  logic [N-1:0]  b_sh;

  logic          last;
  logic          digit_top;
  logic [W-1:0]  digit_ext;
  logic [W-1:0]  pp;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  r;
  logic [N:0]    sign_hi;
  logic          ovf_next;
  logic [N-1:0]  c_next;
  logic [W-1:0]  a_ext;

  // The product is kept modulo 2^W, so the low W bits of a_sh*digit are the same for
  // signed and unsigned interpretation once both are extended to W bits.
  always_comb begin
    last      = (cnt == LAST);
    digit_top = (SIGN != 0 && last) ? b_sh[K-1] : 1'b0;
    digit_ext = {{(W-K){digit_top}}, b_sh[K-1:0]};
    pp        = a_sh * digit_ext;
    acc_next  = acc + pp;

    if (SIGN != 0) r = $signed(acc_next) >>> D;
    else           r = acc_next >> D;

    sign_hi = r[W-1:N-1];
    if (SIGN != 0) ovf_next = !((&sign_hi) || !(|sign_hi));
    else           ovf_next = |r[W-1:N];

    c_next = r[N-1:0];
    if (ovf_next && SAT != 0) begin
      if (SIGN != 0) c_next = r[W-1] ? SMIN : SMAX;
      else           c_next = UMAX;
    end

    if (SIGN != 0) a_ext = {{N{a[N-1]}}, a};
    else           a_ext = {{N{1'b0}}, a};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      recv_rdy <= 1'b1;
      send_val <= 1'b0;
      c        <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            // Seeding the accumulator with the rounding constant folds P + 2^(D-1) into the loop.
            a_sh     <= a_ext;
            b_sh     <= b;
            acc      <= rnd ? RND_ONE : '0;
            cnt      <= '0;
            recv_rdy <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          a_sh <= a_sh << K;
          b_sh <= b_sh >> K;
          cnt  <= cnt + 1'b1;
          if (last) begin
            cnt      <= '0;
            c        <= c_next;
            ovf      <= ovf_next;
            send_val <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (send_rdy) begin
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          recv_rdy <= 1'b1;
          send_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_radix.sv
// Bench for fpmult_radix: directed operand cases, backpressure, reset mid-calculation and
// random operands, all checked by a scoreboard fed from an arithmetic reference model.
module tb_fpmult_radix;

  localparam int N     = 32;
  localparam int D     = 16;
  localparam int SIGN  = 1;
  localparam int K     = 2;
  localparam int SAT   = 1;
  localparam int STEPS = N / K;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         recv_val = 1'b0;
  logic         recv_rdy;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         rnd = 1'b0;
  logic         send_val;
  logic         send_rdy = 1'b1;
  logic [N-1:0] c;
  logic         ovf;

  logic [N:0]   exp_q[$];
  int           lat_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         bp_rand = 1'b0;
  logic         prev_sv = 1'b0;

  fpmult_radix #(.N(N), .D(D), .SIGN(SIGN), .K(K), .SAT(SAT)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .a(a), .b(b), .rnd(rnd), .send_val(send_val), .send_rdy(send_rdy),
    .c(c), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {ovf, c} computed with wide exact integer arithmetic.
  function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                       input logic mr);
    logic signed [127:0] pa, pb, p, r, lo, hi, one;
    logic                o;
    logic [N-1:0]        cc;
    one = 128'sd1;
    if (SIGN != 0) begin
      pa = {{(128-N){ma[N-1]}}, ma};
      pb = {{(128-N){mb[N-1]}}, mb};
      hi = (one <<< (N - 1)) - one;
      lo = -(one <<< (N - 1));
    end else begin
      pa = {{(128-N){1'b0}}, ma};
      pb = {{(128-N){1'b0}}, mb};
      hi = (one <<< N) - one;
      lo = 128'sd0;
    end
    p = pa * pb;
    if (mr && D > 0) p = p + (one <<< (D - 1));
    r = p >>> D;
    o = (r > hi) || (r < lo);
    if (o && SAT != 0) cc = (r < lo) ? lo[N-1:0] : hi[N-1:0];
    else               cc = r[N-1:0];
    return {o, cc};
  endfunction

  task automatic chk(input string name, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = {1'b0, {(N-1){1'b1}}};
      2:       v = {1'b1, {(N-1){1'b0}}};
      3:       v = {N{1'b1}};
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tr,
                       input logic use_exp, input logic [N:0] exp_val);
    int w;
    recv_val = 1'b1;
    a        = ta;
    b        = tb;
    rnd      = tr;
    w        = 0;
    @(negedge clk);
    while (!recv_rdy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!recv_rdy) begin
      chk("accept_timeout", {N+1{1'b0}}, {{N{1'b0}}, 1'b1});
      recv_val = 1'b0;
      return;
    end
    exp_q.push_back(use_exp ? exp_val : model(ta, tb, tr));
    lat_q.push_back(cyc + 1);
    tick();
    recv_val = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", (N+1)'(exp_q.size()), '0);
    tick();
  endtask

  // Random backpressure on the consumer side.
  initial begin
    forever begin
      tick();
      if (bp_rand) send_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [N:0] e;
    int         start;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (send_val && !prev_sv) begin
          if (lat_q.size() == 0) begin
            chk("unexpected_send_val", {{N{1'b0}}, send_val}, '0);
          end else begin
            start = lat_q.pop_front();
            chk("latency", (N+1)'(cyc - start), (N+1)'(STEPS));
          end
        end
        if (send_val && send_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {ovf, c}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("result_c", {1'b0, c}, {1'b0, e[N-1:0]});
            chk("result_ovf", {{N{1'b0}}, ovf}, {{N{1'b0}}, e[N]});
          end
        end
      end
      prev_sv = send_val && !reset;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_recv_rdy", {{N{1'b0}}, recv_rdy}, {{N{1'b0}}, 1'b1});
    chk("reset_send_val", {{N{1'b0}}, send_val}, '0);
    chk("reset_c", {1'b0, c}, '0);
    chk("reset_ovf", {{N{1'b0}}, ovf}, '0);
    tick();
    reset = 1'b0;
    tick();

    // Directed cases with spec-derived expected {ovf, c}.
    issue(32'h0001_8000, 32'h0002_0000, 1'b0, 1'b1, {1'b0, 32'h0003_0000});
    issue(32'hFFFF_0000, 32'h0002_8000, 1'b0, 1'b1, {1'b0, 32'hFFFD_8000});
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, {1'b1, 32'h7FFF_FFFF});
    issue(32'h0000_0001, 32'h0000_8000, 1'b0, 1'b1, {1'b0, 32'h0000_0000});
    issue(32'h0000_0001, 32'h0000_8000, 1'b1, 1'b1, {1'b0, 32'h0000_0001});
    issue(32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 1'b1, {1'b0, 32'h0000_0000});
    issue(32'h7FFF_0000, 32'h0002_0000, 1'b0, 1'b1, {1'b1, 32'h7FFF_FFFF});
    issue(32'h8000_0000, 32'h0002_0000, 1'b1, 1'b1, {1'b1, 32'h8000_0000});
    drain();

    // Backpressure: hold the result for 10 cycles while the operand inputs wander.
    send_rdy = 1'b0;
    issue(32'h0001_8000, 32'h0002_0000, 1'b0, 1'b1, {1'b0, 32'h0003_0000});
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (!send_val && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("bp_send_val_rise", {{N{1'b0}}, send_val}, {{N{1'b0}}, 1'b1});
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_send_val", {{N{1'b0}}, send_val}, {{N{1'b0}}, 1'b1});
      chk("bp_hold_recv_rdy", {{N{1'b0}}, recv_rdy}, '0);
      chk("bp_hold_c_ovf", {ovf, c}, {1'b0, 32'h0003_0000});
      tick();
      a   = rand_op();
      b   = rand_op();
      rnd = 1'(i);
      @(negedge clk);
    end
    tick();
    send_rdy = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("bp_release_recv_rdy", {{N{1'b0}}, recv_rdy}, {{N{1'b0}}, 1'b1});
    chk("bp_release_send_val", {{N{1'b0}}, send_val}, '0);
    tick();

    // Reset in cycle 5 of CALC aborts the transaction.
    issue(32'h1234_5678, 32'h0ABC_DEF0, 1'b1, 1'b0, '0);
    repeat (4) tick();
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    tick();
    @(negedge clk);
    chk("midcalc_reset_recv_rdy", {{N{1'b0}}, recv_rdy}, {{N{1'b0}}, 1'b1});
    chk("midcalc_reset_send_val", {{N{1'b0}}, send_val}, '0);
    chk("midcalc_reset_c_ovf", {ovf, c}, '0);
    tick();
    reset = 1'b0;
    issue(32'h0003_0000, 32'h0004_0000, 1'b0, 1'b1, {1'b0, 32'h000C_0000});
    drain();

    // Random operands with random consumer backpressure and idle gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    drain();
    bp_rand  = 1'b0;
    send_rdy = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpmult_radix.md
Name: fpmult_radix

Overview:
Parametrised successor to the team's radix-2 fixed-point iterative multiplier. Computes c = (a*b) >> D and retires K multiplier bits per cycle, so latency is N/K compute cycles. Adds per-transaction rounding mode, optional saturation and an overflow flag. Sits behind val/rdy producers in the DSP datapath as a drop-in, area-tunable multiplier.

Parameters:
N, 32, operand/result bit width
D, 16, fractional bits (0 <= D < N)
SIGN, 1, 1 = two's-complement operands, 0 = unsigned
K, 2, multiplier bits consumed per CALC cycle; 1 <= K <= N, N % K == 0
SAT, 1, 1 = clamp result on overflow, 0 = wrap (keep low N bits)

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
recv_val  in  1  operands valid
recv_rdy  out  1  ready to accept operands
a  in  N  multiplicand, fixed-point (N-D).D
b  in  N  multiplier, fixed-point (N-D).D
rnd  in  1  rounding mode, sampled with a/b: 0 truncate, 1 round-half-up
send_val  out  1  result valid
send_rdy  in  1  consumer ready
c  out  N  result
ovf  out  1  result exceeded N-bit range; qualified by send_val

Behaviour:
- Reset: state IDLE, cycle counter 0, recv_rdy=1, send_val=0, c=0, ovf=0. Reset in any state, including mid-CALC or DONE, aborts the transaction with no output.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on recv_val. a, b and rnd are latched on that edge.
  - CALC -> DONE when counter == N/K-1. The counter increments once per CALC cycle.
  - DONE -> IDLE on send_rdy.
- Outputs per state:
  - recv_rdy = 1 only in IDLE.
  - send_val = 1 only in DONE.
  - No overlap between transactions.
- Timing: acceptance edge = edge 0. CALC occupies cycles 1..N/K. send_val rises in cycle N/K+1. Back-to-back throughput is one result per N/K+2 cycles.
- DONE hold: c and ovf are stable while send_val=1 and send_rdy=0. Input changes are ignored outside IDLE.
- Arithmetic:
  - P is the exact 2N-bit product, signed if SIGN else unsigned.
  - If rnd=1 and D>0, P' = P + 2^(D-1); otherwise P' = P.
  - R = P' >> D, arithmetic if SIGN.
  - Signed rounding is round-half-toward-+inf.
- Digit processing: each CALC cycle adds partial product a*digit, with digit = K bits of b, LSB-first.
  - Signed case: the final digit's top bit carries negative weight, i.e. two's-complement correction in the last cycle.
  - The internal algorithm is free (plain or Booth recoding) provided exactly N/K CALC cycles and an exact P.
- Overflow: ovf = 1 iff R lies outside the N-bit range.
  - SIGN=1 range: [-2^(N-1), 2^(N-1)-1].
  - SIGN=0 range: [0, 2^N-1].
  - The rounding carry counts toward overflow.
- Result c:
  - No overflow: c = R[N-1:0].
  - Overflow, SAT=1: c clamps to the max or min of the range, by the sign of R (unsigned clamps to 2^N-1).
  - Overflow, SAT=0: c = R[N-1:0].
- Degenerate parameters:
  - K=N: a single CALC cycle.
  - D=0: integer multiply; rnd has no effect.

Test Plan:
- Basic, defaults: a=0x00018000 (1.5), b=0x00020000 (2.0), rnd=0 -> c=0x00030000, ovf=0, send_val first high in cycle 17.
- Signed: a=0xFFFF0000 (-1.0), b=0x00028000 (2.5) -> c=0xFFFD8000, ovf=0. Also a=0x80000000, b=0x80000000 -> ovf=1, c=0x7FFFFFFF with SAT=1.
- Rounding: a=0x00000001, b=0x00008000 -> rnd=0 gives c=0x00000000; rnd=1 gives c=0x00000001. a=0xFFFFFFFF, b=0x00008000, rnd=1 -> c=0x00000000 (half rounds toward +inf).
- Overflow: a=0x7FFF0000, b=0x00020000 -> ovf=1; SAT=1 gives c=0x7FFFFFFF; SAT=0 build gives c=0xFFFE0000.
- Handshake/backpressure: hold send_rdy=0 for 10 cycles in DONE -> c, ovf, send_val stable and recv_rdy=0. Toggle a/b meanwhile -> no effect. Release -> next transaction accepted the following cycle.
- Reset mid-CALC (cycle 5) -> next cycle IDLE, recv_rdy=1, send_val=0, c=0. A fresh 3*4 integer transaction (a=0x00030000, b=0x00040000) then yields c=0x000C0000. Repeat with K=1 (33-cycle latency) and K=N (2-cycle latency) builds, checked against a reference model over 10k random operands per SIGN/SAT/rnd combination.
